pixel_fifo: RTL and testbench

PIXEL_FIFO -- requirements
Module: pixel_fifo

---
 rtl/pixel_fifo.sv | 118 +++++++++++
 tb/tb_pixel_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO: registered read port, no fall-through, sticky overflow/underflow.
// Status flags decode the registered occupancy; flush clears control state in one cycle.
module pixel_fifo #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_L    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_L    = AE_LEVEL[ADDR_W:0];

  if (ADDR_W < 2 || DATA_W < 1 || AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH)
  begin : g_bad_params
    $error("pixel_fifo: illegal parameter combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc;

  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc = rd_en & ~flush & ~empty;
  assign wr_acc = wr_en & ~flush & (~full | rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (wr_en && !wr_acc) ovf_d = 1'b1;
      if (rd_en && empty)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is left unreset so it maps onto RAM.
  always_ff @(posedge clk_100mhz) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_pixel_fifo.sv
// Bench for pixel_fifo: queue-based reference model, directed scenarios and random traffic.
module tb_pixel_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [23:0] wr_data = '0;
  logic [23:0] rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  level;

  logic        s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [7:0]  s_wr_data = '0;
  logic [7:0]  s_rd_data;
  logic        s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [3:0]  s_level;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] q[$];
  logic [23:0] m_rdd;
  logic        m_vld, m_ovf, m_unf;

  logic [35:0] dut_stat;
  assign dut_stat = {level, full, empty, almost_full, almost_empty, overflow, underflow,
                     rd_valid, rd_data};

  always #5 clk = ~clk;

  pixel_fifo u_dut (
    .clk_100mhz(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  pixel_fifo #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) u_small (
    .clk_100mhz(clk), .rst(rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf)
  );

  function automatic logic [35:0] exp_status();
    int sz;
    sz = q.size();
    return {5'(sz), sz == 16, sz == 0, sz >= 14, sz <= 2, m_ovf, m_unf, m_vld, m_rdd};
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdd = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic step(input bit w, input logic [23:0] d, input bit r, input bit f);
    bit rd_ok, wr_ok;
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < 16) || rd_ok);
      if (r && q.size() == 0) m_unf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      m_vld = rd_ok;
      if (rd_ok) m_rdd = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if (dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_stat, exp_status());
    end
    n_vec++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || level !== 5'd0 || rd_data !== 24'd0) begin
      n_err++;
      $display("FAIL reset_flags: empty=%b ae=%b level=%0d rd_data=%h want 1 1 0 0",
               empty, almost_empty, level, rd_data);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 24'(i), 1'b0, 1'b0);
      n_vec++;
      if (dut_stat !== exp_status() || level !== 5'(i) || almost_full !== (i >= 14)) begin
        n_err++;
        $display("FAIL fill_%0d: got %h want %h", i, dut_stat, exp_status());
      end
    end
    step(1'b1, 24'd17, 1'b0, 1'b0);
    n_vec++;
    if (overflow !== 1'b1 || full !== 1'b1 || dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL overflow_17th: ovf=%b full=%b want 1 1", overflow, full);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 24'(i) || dut_stat !== exp_status()) begin
        n_err++;
        $display("FAIL drain_%0d: vld=%b data=%h want 1 %h", i, rd_valid, rd_data, 24'(i));
      end
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (rd_valid !== 1'b0 || dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL drain_idle: got %h want %h", dut_stat, exp_status());
    end
  endtask

  task automatic test_underflow();
    logic [23:0] held;
    held = rd_data;
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== held) begin
      n_err++;
      $display("FAIL underflow: unf=%b vld=%b data=%h want 1 0 %h", underflow, rd_valid,
               rd_data, held);
    end
    step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
    n_vec++;
    if (level !== 5'd1 || rd_valid !== 1'b0 || dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL wr_rd_empty: level=%0d vld=%b want 1 0", level, rd_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (rd_data !== 24'hABCDEF || rd_valid !== 1'b1 || dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL read_abcdef: data=%h vld=%b want abcdef 1", rd_data, rd_valid);
    end
  endtask

  task automatic test_back_to_back_full();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 24'h100 + 24'(i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 24'h110 + 24'(k), 1'b1, 1'b0);
      n_vec++;
      if (level !== 5'd16 || overflow !== 1'b0 || rd_data !== 24'h100 + 24'(k) ||
          dut_stat !== exp_status()) begin
        n_err++;
        $display("FAIL b2b_%0d: level=%0d ovf=%b data=%h want 16 0 %h", k, level, overflow,
                 rd_data, 24'h100 + 24'(k));
      end
    end
  endtask

  task automatic test_flush();
    logic [23:0] held;
    step(1'b1, 24'hDEAD00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (level !== 5'd9 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flush_setup: level=%0d ovf=%b want 9 1", level, overflow);
    end
    held = rd_data;
    step(1'b1, 24'h555555, 1'b1, 1'b1);
    n_vec++;
    if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== held || dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL flush: got %h want %h", dut_stat, exp_status());
    end
    step(1'b1, 24'h654321, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (rd_data !== 24'h654321 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_roundtrip: data=%h vld=%b want 654321 1", rd_data, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1'b1, 24'hA0 + 24'(i), 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", dut_stat, exp_status());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", dut_stat, exp_status());
    end
    step(1'b1, 24'h123456, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if (rd_data !== 24'h123456 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_read: data=%h vld=%b want 123456 1", rd_data, rd_valid);
    end
  endtask

  task automatic test_random();
    bit w, r, f;
    for (int c = 0; c < 600; c++) begin
      w = (c % 200 < 100) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (c % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      f = ($urandom_range(63) == 0);
      step(w, 24'($urandom), r, f);
      n_vec++;
      if (dut_stat !== exp_status()) begin
        n_err++;
        $display("FAIL random_%0d: got %h want %h", c, dut_stat, exp_status());
      end
    end
  endtask

  task automatic test_small_params();
    for (int i = 1; i <= 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = 8'(i);
      @(posedge clk); #1;
      n_vec++;
      if (s_level !== 4'(i) || s_full !== (i == 8) || s_af !== (i >= 6) || s_ae !== (i <= 1)) begin
        n_err++;
        $display("FAIL small_fill_%0d: level=%0d full=%b af=%b ae=%b", i, s_level, s_full,
                 s_af, s_ae);
      end
    end
    s_wr_data = 8'd9;
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    n_vec++;
    if (s_ovf !== 1'b1 || s_level !== 4'd8) begin
      n_err++;
      $display("FAIL small_overflow: ovf=%b level=%0d want 1 8", s_ovf, s_level);
    end
    for (int i = 1; i <= 8; i++) begin
      s_rd_en = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (s_rd_valid !== 1'b1 || s_rd_data !== 8'(i) || s_level !== 4'(8 - i) ||
          s_ae !== ((8 - i) <= 1) || s_af !== ((8 - i) >= 6)) begin
        n_err++;
        $display("FAIL small_drain_%0d: vld=%b data=%h level=%0d ae=%b af=%b", i, s_rd_valid,
                 s_rd_data, s_level, s_ae, s_af);
      end
    end
    s_rd_en = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (s_rd_valid !== 1'b0 || s_empty !== 1'b1) begin
      n_err++;
      $display("FAIL small_idle: vld=%b empty=%b want 0 1", s_rd_valid, s_empty);
    end
  endtask

  initial begin
    model_reset();
    #1;
    n_vec++;
    if (dut_stat !== exp_status()) begin
      n_err++;
      $display("FAIL reset_async_start: got %h want %h", dut_stat, exp_status());
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back_full();
    test_flush();
    test_reset_mid();
    test_random();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
